// File: rtl/alex_relay_sequencer.sv
// alex_relay_sequencer
// Sequences updates to the Alex filter board relays. When either requested
// word changes, or after reset, the PA is inhibited. Both words are then
// shifted out MSB first and each is latched with its load strobe. TX is
// released only after a relay settle interval.
//
// Ports:
//   clock          in   system clock
//   reset          in   asynchronous, active-high reset
//   tx_word[15:0]  in   requested TX relay word (bits [6:0] = LPF code)
//   rx_word[15:0]  in   requested RX relay word
//   SPI_data       out  serial data, MSB first, 0 outside shifting
//   SPI_clock      out  serial clock, idles low
//   Tx_load_strobe out  latches the TX shift register on Alex
//   Rx_load_strobe out  latches the RX shift register on Alex
//   tx_inhibit     out  high means PA keying is forbidden
//   busy           out  high while a sequence is in progress
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | relays match shadow words, waiting for a change
// GUARD    | PA inhibited, waiting before the first shifted bit
// SHIFT_TX | shifting shadow_tx, bit 15 first
// LOAD_TX  | Tx_load_strobe high
// SHIFT_RX | shifting shadow_rx, bit 15 first
// LOAD_RX  | Rx_load_strobe high
// SETTLE   | waiting for the relays to settle before releasing TX

module alex_relay_sequencer #(
  parameter int CLK_DIV = 8,
  parameter int GUARD   = 64,
  parameter int SETTLE  = 122880
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] tx_word,
  input  logic [15:0] rx_word,
  output logic        SPI_data,
  output logic        SPI_clock,
  output logic        Tx_load_strobe,
  output logic        Rx_load_strobe,
  output logic        tx_inhibit,
  output logic        busy
);

  localparam int MAX_GS = (GUARD > SETTLE) ? GUARD : SETTLE;
  localparam int MAX_ALL = (MAX_GS > CLK_DIV) ? MAX_GS : CLK_DIV;
  localparam int CW = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] GUARD_LOAD  = CW'(GUARD - 1);
  localparam logic [CW-1:0] DIV_LOAD    = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GUARD,
    S_SHIFT_TX,
    S_LOAD_TX,
    S_SHIFT_RX,
    S_LOAD_RX,
    S_SETTLE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   shadow_tx_q, shadow_tx_d;
  logic [15:0]   shadow_rx_q, shadow_rx_d;
  logic          init_q, init_d;
  logic          spi_data_d, spi_clock_d, tx_strobe_d, rx_strobe_d;
  logic          tx_inhibit_d, busy_d;
  logic          changed;
  logic          cnt_last;
  logic [15:0]   shift_word;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      bit_q          <= '0;
      shadow_tx_q    <= '0;
      shadow_rx_q    <= '0;
      init_q         <= 1'b1;
      SPI_data       <= 1'b0;
      SPI_clock      <= 1'b0;
      Tx_load_strobe <= 1'b0;
      Rx_load_strobe <= 1'b0;
      tx_inhibit     <= 1'b1;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bit_q          <= bit_d;
      shadow_tx_q    <= shadow_tx_d;
      shadow_rx_q    <= shadow_rx_d;
      init_q         <= init_d;
      SPI_data       <= spi_data_d;
      SPI_clock      <= spi_clock_d;
      Tx_load_strobe <= tx_strobe_d;
      Rx_load_strobe <= rx_strobe_d;
      tx_inhibit     <= tx_inhibit_d;
      busy           <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shadow_tx_d  = shadow_tx_q;
    shadow_rx_d  = shadow_rx_q;
    init_d       = init_q;
    spi_data_d   = SPI_data;
    spi_clock_d  = SPI_clock;
    tx_strobe_d  = Tx_load_strobe;
    rx_strobe_d  = Rx_load_strobe;
    tx_inhibit_d = tx_inhibit;
    busy_d       = busy;
    changed      = init_q || (tx_word != shadow_tx_q) || (rx_word != shadow_rx_q);
    cnt_last     = (cnt_q == '0);
    shift_word   = (state_q == S_SHIFT_TX) ? shadow_tx_q : shadow_rx_q;

    case (state_q)
      S_IDLE: begin
        if (changed) begin
          shadow_tx_d  = tx_word;
          shadow_rx_d  = rx_word;
          init_d       = 1'b0;
          busy_d       = 1'b1;
          tx_inhibit_d = 1'b1;
          cnt_d        = GUARD_LOAD;
          state_d      = S_GUARD;
        end
      end
      S_GUARD: begin
        if (cnt_last) begin
          state_d    = S_SHIFT_TX;
          cnt_d      = DIV_LOAD;
          bit_d      = 4'd15;
          spi_data_d = shadow_tx_q[15];
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_SHIFT_TX, S_SHIFT_RX: begin
        // SPI_clock doubles as the half-period phase; the next bit is
        // presented on the same edge that drops the clock.
        if (!cnt_last) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!SPI_clock) begin
          spi_clock_d = 1'b1;
          cnt_d       = DIV_LOAD;
        end else begin
          spi_clock_d = 1'b0;
          cnt_d       = DIV_LOAD;
          if (bit_q == 4'd0) begin
            spi_data_d = 1'b0;
            if (state_q == S_SHIFT_TX) begin
              tx_strobe_d = 1'b1;
              state_d     = S_LOAD_TX;
            end else begin
              rx_strobe_d = 1'b1;
              state_d     = S_LOAD_RX;
            end
          end else begin
            bit_d      = bit_q - 4'd1;
            spi_data_d = shift_word[bit_q - 4'd1];
          end
        end
      end
      S_LOAD_TX: begin
        if (cnt_last) begin
          tx_strobe_d = 1'b0;
          state_d     = S_SHIFT_RX;
          cnt_d       = DIV_LOAD;
          bit_d       = 4'd15;
          spi_data_d  = shadow_rx_q[15];
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_LOAD_RX: begin
        if (cnt_last) begin
          rx_strobe_d = 1'b0;
          state_d     = S_SETTLE;
          cnt_d       = SETTLE_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_last) begin
          state_d = S_IDLE;
          // A pending change keeps TX inhibited; IDLE restarts on the next edge.
          if (!changed) begin
            busy_d       = 1'b0;
            tx_inhibit_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
